// File: rtl/lcd_pio_pkg.sv
// Shared register offsets and edge-select constants for the LCD-board PIO blocks.
// Used by both the push-button input PIO and the LED output PIO.
package lcd_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/lcd_pio_debounce.sv
// One-bit debouncer: the output follows the input only after the input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module lcd_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter is cleared on any cycle the input agrees, so it never passes LIMIT.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (din != stable_q) begin
      if (cnt_q >= LIMIT) begin
        stable_d = din;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/lcd_button_pio.sv
// Avalon-MM input PIO for the LCD-board push-buttons: data, edge-capture and masked irq.
// Define LCD_BUTTON_DEBOUNCE_EN to insert a per-bit debouncer after the synchroniser.
module lcd_button_pio
  import lcd_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] stable, rise, fall, edge_det;
  logic             wr_en;

`ifdef LCD_BUTTON_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    lcd_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (sync2_q[i]),
      .stable (stable[i])
    );
  end
`else
  assign stable = sync2_q;
`endif

  assign wr_en = chipselect & ~write_n;
  assign rise  = stable & ~prev_q;
  assign fall  = ~stable & prev_q;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = rise;
      EDGE_FALL: edge_det = fall;
      default:   edge_det = rise | fall;
    endcase
  end

  // Set is OR'd in after the clear so a same-cycle edge wins over write-1-to-clear.
  always_comb begin
    sync1_d        = in_port;
    sync2_d        = sync1_q;
    prev_d         = stable;
    irq_mask_d     = irq_mask_q;
    edge_capture_d = edge_capture_q;
    if (wr_en && address == ADDR_IRQ_MASK) irq_mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE_CAP) edge_capture_d = edge_capture_q & ~writedata[WIDTH-1:0];
    edge_capture_d = edge_capture_d | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      prev_q         <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0] = stable;
      ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_capture_q;
      default:       readdata = '0;
    endcase
  end

  assign irq = |(edge_capture_q & irq_mask_q);

  // Upper writedata bits and, without the debouncer, DEBOUNCE_CYCLES have no function.
  logic unused_ok;
  assign unused_ok = &{1'b0, writedata, DEBOUNCE_CYCLES[0]};

endmodule

// File: tb/tb_lcd_button_pio.sv
// Directed self-checking bench for lcd_button_pio (WIDTH=4, falling-edge capture).
// With LCD_BUTTON_DEBOUNCE_EN defined it also covers glitch rejection at DEBOUNCE_CYCLES=8.
module tb_lcd_button_pio;

`ifdef LCD_BUTTON_DEBOUNCE_EN
  localparam int D = 10;
`else
  localparam int D = 2;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp;
  int n_bad;

  lcd_button_pio #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // reset state with inputs held high
    tick(3);
    check_reg("rst_data", 2'd0, 32'h0);
    check_reg("rst_mask", 2'd2, 32'h0);
    check_reg("rst_cap", 2'd3, 32'h0);
    check_irq("rst_irq", 1'b0);

    reset_n = 1'b1;
    tick(D - 1);
    check_reg("rel_data_early", 2'd0, 32'h0);
    tick(1);
    check_reg("rel_data", 2'd0, 32'hF);
    tick(2);
    check_reg("rel_cap", 2'd3, 32'h0);
    check_irq("rel_irq", 1'b0);

    // bus map
    check_reg("rsvd_read", 2'd1, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    check_reg("mask_trunc", 2'd2, 32'h0000_000F);
    bus_write(2'd2, 32'h0000_0001);
    check_reg("mask_one", 2'd2, 32'h1);

    // falling edge on bit 0
    in_port = 4'hE;
    tick(D);
    check_reg("fall_data", 2'd0, 32'hE);
    check_reg("fall_cap_early", 2'd3, 32'h0);
    tick(1);
    check_reg("fall_cap", 2'd3, 32'h1);
    check_irq("fall_irq", 1'b1);
    bus_write(2'd3, 32'h1);
    check_reg("w1c_cap", 2'd3, 32'h0);
    check_irq("w1c_irq", 1'b0);

    // W1C on the same edge that captures a new fall: set wins
    in_port = 4'hF;
    tick(D + 2);
    check_reg("rise_nocap", 2'd3, 32'h0);
    in_port = 4'hE;
    tick(D);
    bus_write(2'd3, 32'h1);
    check_reg("collide_cap", 2'd3, 32'h1);
    check_irq("collide_irq", 1'b1);
    bus_write(2'd3, 32'h1);
    check_reg("collide_clr", 2'd3, 32'h0);

    // masked edge on bit 2, then unmask
    bus_write(2'd2, 32'h0);
    in_port = 4'hA;
    tick(D + 1);
    check_reg("mask_cap", 2'd3, 32'h4);
    check_irq("mask_irq0", 1'b0);
    bus_write(2'd2, 32'h4);
    check_irq("unmask_irq", 1'b1);
    check_reg("unmask_cap", 2'd3, 32'h4);

    // W1C of another bit leaves bit 2; writes to reserved or without chipselect are ignored
    bus_write(2'd3, 32'h1);
    check_reg("w1c_other", 2'd3, 32'h4);
    bus_write(2'd1, 32'hFFFF_FFFF);
    check_reg("rsvd_wr", 2'd1, 32'h0);
    check_reg("rsvd_wr_mask", 2'd2, 32'h4);
    address   = 2'd2;
    writedata = 32'h0;
    write_n   = 1'b0;
    tick(1);
    write_n   = 1'b1;
    check_reg("nocs_mask", 2'd2, 32'h4);
    bus_write(2'd3, 32'hFFFF_FFF4);
    check_reg("w1c_bit2", 2'd3, 32'h0);
    check_irq("w1c_bit2_irq", 1'b0);

    // several bits fall together (bits 3 and 1: 0xA -> 0x0)
    in_port = 4'h0;
    tick(D + 1);
    check_reg("multi_data", 2'd0, 32'h0);
    check_reg("multi_cap", 2'd3, 32'hA);
    check_irq("multi_irq_masked", 1'b0);
    bus_write(2'd2, 32'h8);
    check_irq("multi_irq", 1'b1);

    // asynchronous reset mid-operation drops captures and mask
    reset_n = 1'b0;
    #1;
    check_irq("midrst_irq", 1'b0);
    check_reg("midrst_cap", 2'd3, 32'h0);
    check_reg("midrst_mask", 2'd2, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(D + 2);
    check_reg("postrst_cap", 2'd3, 32'h0);

`ifdef LCD_BUTTON_DEBOUNCE_EN
    // bring inputs high, then glitch bit 0 low for 5 and 7 cycles
    in_port = 4'hF;
    tick(D + 2);
    check_reg("db_high", 2'd0, 32'hF);
    in_port = 4'hE;
    tick(5);
    in_port = 4'hF;
    tick(20);
    check_reg("db_g5_data", 2'd0, 32'hF);
    check_reg("db_g5_cap", 2'd3, 32'h0);
    in_port = 4'hE;
    tick(7);
    in_port = 4'hF;
    tick(20);
    check_reg("db_g7_data", 2'd0, 32'hF);
    check_reg("db_g7_cap", 2'd3, 32'h0);
    in_port = 4'hE;
    tick(D);
    check_reg("db_hold_data", 2'd0, 32'hE);
    check_reg("db_hold_cap_early", 2'd3, 32'h0);
    tick(1);
    check_reg("db_hold_cap", 2'd3, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
